// File: rtl/sd_card_cmd_responder_if.sv
// ---------------------------------------------------------------------------
// sd_card_cmd_responder_if
// Signal bundle between the SD CMD-line responder and its surroundings.
//   cmd_from_host   host-driven CMD line (idle high)
//   card_status     status word returned in R1 responses
//   cmd_to_host     response bit onto the CMD line
//   cmd_to_host_oe  output enable for cmd_to_host
//   cmd_index       index of the last accepted frame
//   cmd_arg         argument of the last accepted frame
//   cmd_valid       pulse: good frame received
//   crc_error       pulse: CRC7 mismatch
//   frame_error     pulse: transmission or end bit wrong
//   resp_done       pulse: response end bit on the line
// master = host / card-logic side, slave = responder.
// ---------------------------------------------------------------------------
interface sd_card_cmd_responder_if;
   logic        cmd_from_host;
   logic [31:0] card_status;
   logic        cmd_to_host;
   logic        cmd_to_host_oe;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        cmd_valid;
   logic        crc_error;
   logic        frame_error;
   logic        resp_done;

   modport master (
      output cmd_from_host, card_status,
      input  cmd_to_host, cmd_to_host_oe, cmd_index, cmd_arg,
             cmd_valid, crc_error, frame_error, resp_done
   );

   modport slave (
      input  cmd_from_host, card_status,
      output cmd_to_host, cmd_to_host_oe, cmd_index, cmd_arg,
             cmd_valid, crc_error, frame_error, resp_done
   );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// ---------------------------------------------------------------------------
// sd_card_cmd_responder
// Card-side end of the SD CMD line. Receives 48-bit host command frames,
// checks transmission/end bits and CRC7, reports index/argument, and answers
// with a 48-bit R1-format response after an NCR-cycle gap.
//   sd_clk  card clock, all logic on its rising edge
//   rst_L   synchronous active-low reset
//   bus     sd_card_cmd_responder_if.slave (CMD line in/out, status, pulses)
//
// state | meaning
// IDLE  | line idle, waiting for a start bit (0)
// RECV  | shifting in frame bits 1..47
// CHECK | one cycle: validate frame, raise result pulse, preload response
// WAIT  | NCR gap, line released
// SEND  | driving the 48 response bits
// ---------------------------------------------------------------------------
module sd_card_cmd_responder #(
   parameter int         NCR        = 2,
   parameter logic [5:0] NORESP_IDX = 6'd0
) (
   input logic                      sd_clk,
   input logic                      rst_L,
   sd_card_cmd_responder_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, RECV, CHECK, WAIT, SEND} state_t;

   state_t      state, state_nxt;
   logic [5:0]  bit_cnt;
   logic [6:0]  gap_cnt;
   logic [6:0]  crc_rx;
   logic [46:0] rx_sr;
   logic [47:0] tx_sr;
   logic [5:0]  cmd_index_q;
   logic [31:0] cmd_arg_q;
   logic        cmd_valid_q, crc_error_q, frame_error_q, resp_done_q;
   logic        cmd_out_q, cmd_oe_q;

   // CRC7, polynomial x^7 + x^3 + 1, one bit per step
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      return {c[5:3], c[2] ^ fb, c[1:0], fb};
   endfunction

   function automatic logic [6:0] crc7_40(input logic [39:0] d);
      logic [6:0] c;
      c = '0;
      for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
      return c;
   endfunction

   // rx_sr holds frame bits 1..47 once the end bit is in; bit 1 sits at [46]
   logic        rx_tx_bit, rx_end_bit, frame_bad, crc_bad, no_resp;
   logic [5:0]  rx_idx;
   logic [31:0] rx_arg;
   logic [6:0]  rx_crc;
   logic [39:0] resp_hdr;

   always_comb begin
      rx_tx_bit  = rx_sr[46];
      rx_idx     = rx_sr[45:40];
      rx_arg     = rx_sr[39:8];
      rx_crc     = rx_sr[7:1];
      rx_end_bit = rx_sr[0];
      frame_bad  = !rx_tx_bit || !rx_end_bit;
      crc_bad    = rx_crc != crc_rx;
      no_resp    = rx_idx == NORESP_IDX;
      resp_hdr   = {2'b00, rx_idx, bus.card_status};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!bus.cmd_from_host) state_nxt = RECV;
         RECV:    if (bit_cnt == 6'd47) state_nxt = CHECK;
         CHECK:   state_nxt = (frame_bad || crc_bad || no_resp) ? IDLE : WAIT;
         WAIT:    if (gap_cnt == 7'd0) state_nxt = SEND;
         SEND:    if (bit_cnt == 6'd47) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sd_clk) begin
      if (!rst_L) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         gap_cnt       <= '0;
         crc_rx        <= '0;
         rx_sr         <= '0;
         tx_sr         <= '0;
         cmd_index_q   <= '0;
         cmd_arg_q     <= '0;
         cmd_valid_q   <= 1'b0;
         crc_error_q   <= 1'b0;
         frame_error_q <= 1'b0;
         resp_done_q   <= 1'b0;
         cmd_out_q     <= 1'b1;
         cmd_oe_q      <= 1'b0;
      end else begin
         state         <= state_nxt;
         cmd_valid_q   <= 1'b0;
         crc_error_q   <= 1'b0;
         frame_error_q <= 1'b0;
         resp_done_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (!bus.cmd_from_host) begin
                  bit_cnt <= 6'd1;
                  rx_sr   <= '0;
                  crc_rx  <= crc7_step(7'd0, bus.cmd_from_host);
               end
            end
            RECV: begin
               rx_sr <= {rx_sr[45:0], bus.cmd_from_host};
               if (bit_cnt <= 6'd39) crc_rx <= crc7_step(crc_rx, bus.cmd_from_host);
               if (bit_cnt != 6'd47) bit_cnt <= bit_cnt + 6'd1;
            end
            CHECK: begin
               bit_cnt <= '0;
               if (frame_bad) begin
                  frame_error_q <= 1'b1;
               end else if (crc_bad) begin
                  crc_error_q <= 1'b1;
               end else begin
                  cmd_valid_q <= 1'b1;
                  cmd_index_q <= rx_idx;
                  cmd_arg_q   <= rx_arg;
                  if (!no_resp) begin
                     tx_sr   <= {resp_hdr, crc7_40(resp_hdr), 1'b1};
                     // the CHECK cycle counts as the first gap cycle
                     gap_cnt <= 7'(NCR - 1);
                  end
               end
            end
            WAIT: begin
               if (gap_cnt == 7'd0) begin
                  cmd_oe_q  <= 1'b1;
                  cmd_out_q <= tx_sr[47];
                  tx_sr     <= {tx_sr[46:0], 1'b0};
                  bit_cnt   <= '0;
               end else begin
                  gap_cnt <= gap_cnt - 7'd1;
               end
            end
            SEND: begin
               if (bit_cnt == 6'd47) begin
                  cmd_oe_q  <= 1'b0;
                  cmd_out_q <= 1'b1;
                  bit_cnt   <= '0;
               end else begin
                  cmd_out_q   <= tx_sr[47];
                  tx_sr       <= {tx_sr[46:0], 1'b0};
                  bit_cnt     <= bit_cnt + 6'd1;
                  resp_done_q <= (bit_cnt == 6'd46);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_to_host    = cmd_out_q;
   assign bus.cmd_to_host_oe = cmd_oe_q;
   assign bus.cmd_index      = cmd_index_q;
   assign bus.cmd_arg        = cmd_arg_q;
   assign bus.cmd_valid      = cmd_valid_q;
   assign bus.crc_error      = crc_error_q;
   assign bus.frame_error    = frame_error_q;
   assign bus.resp_done      = resp_done_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_sd_card_cmd_responder
// Two responders (NCR=2 and NCR=64) driven by directed host frames. Expected
// pulses and responses are queued when a frame is issued; a negedge monitor
// pops and compares whenever a DUT shows a pulse or drives a response.
// ---------------------------------------------------------------------------
module tb_sd_card_cmd_responder;

   logic sd_clk = 1'b0;
   logic rst_L;
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   always #5 sd_clk = ~sd_clk;
   always @(posedge sd_clk) cyc <= cyc + 1;

   sd_card_cmd_responder_if bus_a ();
   sd_card_cmd_responder_if bus_b ();

   sd_card_cmd_responder #(.NCR(2), .NORESP_IDX(6'd0)) dut_a (
      .sd_clk (sd_clk),
      .rst_L  (rst_L),
      .bus    (bus_a.slave)
   );

   sd_card_cmd_responder #(.NCR(64), .NORESP_IDX(6'd0)) dut_b (
      .sd_clk (sd_clk),
      .rst_L  (rst_L),
      .bus    (bus_b.slave)
   );

   // per-DUT views so one monitor loop serves both
   logic        oe_v [2];
   logic        out_v [2];
   logic [2:0]  pulse_v [2];
   logic        done_v [2];
   logic [5:0]  idx_v [2];
   logic [31:0] arg_v [2];

   assign oe_v[0]    = bus_a.cmd_to_host_oe;
   assign out_v[0]   = bus_a.cmd_to_host;
   assign pulse_v[0] = {bus_a.cmd_valid, bus_a.crc_error, bus_a.frame_error};
   assign done_v[0]  = bus_a.resp_done;
   assign idx_v[0]   = bus_a.cmd_index;
   assign arg_v[0]   = bus_a.cmd_arg;
   assign oe_v[1]    = bus_b.cmd_to_host_oe;
   assign out_v[1]   = bus_b.cmd_to_host;
   assign pulse_v[1] = {bus_b.cmd_valid, bus_b.crc_error, bus_b.frame_error};
   assign done_v[1]  = bus_b.resp_done;
   assign idx_v[1]   = bus_b.cmd_index;
   assign arg_v[1]   = bus_b.cmd_arg;

   localparam logic [2:0] EV_VALID = 3'b100;
   localparam logic [2:0] EV_CRC   = 3'b010;
   localparam logic [2:0] EV_FRAME = 3'b001;

   typedef struct {
      logic [2:0]  vec;
      logic [5:0]  idx;
      logic [31:0] arg;
   } ev_t;

   typedef struct {
      logic [47:0] bits;
      int          nbits;
      int          gap;
   } rs_t;

   ev_t ev_q [2][$];
   rs_t rs_q [2][$];

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // long-division CRC7 remainder of msg * x^7 by x^7 + x^3 + 1
   function automatic logic [6:0] crc7_model(input logic [39:0] m);
      logic [46:0] r;
      r = {m, 7'd0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'b1000_1001;
      return r[6:0];
   endfunction

   function automatic logic [47:0] mk_frame(input logic tx, input logic [5:0] idx,
                                            input logic [31:0] arg, input logic [6:0] crc,
                                            input logic endb);
      return {1'b0, tx, idx, arg, crc, endb};
   endfunction

   function automatic logic [47:0] mk_resp(input logic [5:0] idx, input logic [31:0] st);
      logic [39:0] h;
      h = {2'b00, idx, st};
      return {h, crc7_model(h), 1'b1};
   endfunction

   task automatic drive(input int d, input logic v);
      if (d == 0) bus_a.cmd_from_host = v;
      else        bus_b.cmd_from_host = v;
   endtask

   // caller sits at a negedge; returns at the negedge right after the end-bit edge
   task automatic send(input int d, input logic [47:0] f);
      for (int i = 47; i >= 0; i--) begin
         drive(d, f[i]);
         @(negedge sd_clk);
      end
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge sd_clk);
   endtask

   // ---------------- monitor / scoreboard ----------------
   int          pulse_cyc [2];
   int          nrx [2];
   int          done_at [2];
   logic [47:0] rx [2];
   logic        active [2];
   logic        has_exp [2];
   rs_t         cur [2];

   initial begin
      for (int d = 0; d < 2; d++) begin
         pulse_cyc[d] = 0;
         nrx[d]       = 0;
         done_at[d]   = 0;
         rx[d]        = '0;
         active[d]    = 1'b0;
         has_exp[d]   = 1'b0;
      end
   end

   always @(negedge sd_clk) begin
      ev_t e;
      for (int d = 0; d < 2; d++) begin
         if (rst_L === 1'b1 && pulse_v[d] != 3'b000) begin
            if (ev_q[d].size() == 0) begin
               chk($sformatf("unexpected_pulse_dut%0d", d), 48'(pulse_v[d]), 48'd0);
            end else begin
               e = ev_q[d].pop_front();
               chk($sformatf("pulse_kind_dut%0d", d), 48'(pulse_v[d]), 48'(e.vec));
               chk($sformatf("cmd_index_dut%0d", d), 48'(idx_v[d]), 48'(e.idx));
               chk($sformatf("cmd_arg_dut%0d", d), 48'(arg_v[d]), 48'(e.arg));
               pulse_cyc[d] = cyc;
            end
         end
         if (oe_v[d] === 1'b1 && !active[d]) begin
            active[d]  = 1'b1;
            nrx[d]     = 0;
            rx[d]      = '0;
            done_at[d] = 0;
            if (rs_q[d].size() == 0) begin
               has_exp[d] = 1'b0;
               chk($sformatf("unexpected_resp_dut%0d", d), 48'd1, 48'd0);
            end else begin
               has_exp[d] = 1'b1;
               cur[d] = rs_q[d].pop_front();
               chk($sformatf("ncr_gap_dut%0d", d), 48'(cyc - pulse_cyc[d]), 48'(cur[d].gap));
            end
         end
         if (oe_v[d] === 1'b1) begin
            rx[d] = {rx[d][46:0], out_v[d]};
            nrx[d]++;
            if (done_v[d]) done_at[d] = nrx[d];
         end else begin
            if (done_v[d] === 1'b1)
               chk($sformatf("stray_resp_done_dut%0d", d), 48'd1, 48'd0);
            if (active[d]) begin
               active[d] = 1'b0;
               if (has_exp[d]) begin
                  chk($sformatf("resp_len_dut%0d", d), 48'(nrx[d]), 48'(cur[d].nbits));
                  chk($sformatf("resp_bits_dut%0d", d), rx[d],
                      cur[d].bits >> (48 - cur[d].nbits));
                  chk($sformatf("resp_done_pos_dut%0d", d), 48'(done_at[d]),
                      (cur[d].nbits == 48) ? 48'd48 : 48'd0);
                  chk($sformatf("line_idle_after_resp_dut%0d", d), 48'(out_v[d]), 48'd1);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      ev_t         ev;
      rs_t         rs;
      int          e;
      logic [6:0]  crc17;

      rst_L = 1'b0;
      bus_a.cmd_from_host = 1'b1;
      bus_b.cmd_from_host = 1'b1;
      bus_a.card_status   = '0;
      bus_b.card_status   = '0;
      repeat (3) @(negedge sd_clk);

      chk("rst_oe_a",    48'(bus_a.cmd_to_host_oe), 48'd0);
      chk("rst_line_a",  48'(bus_a.cmd_to_host), 48'd1);
      chk("rst_index_a", 48'(bus_a.cmd_index), 48'd0);
      chk("rst_arg_a",   48'(bus_a.cmd_arg), 48'd0);
      chk("rst_pulses_a", 48'(pulse_v[0]), 48'd0);
      chk("rst_done_a",  48'(bus_a.resp_done), 48'd0);
      chk("rst_oe_b",    48'(bus_b.cmd_to_host_oe), 48'd0);
      chk("rst_line_b",  48'(bus_b.cmd_to_host), 48'd1);
      rst_L = 1'b1;
      @(negedge sd_clk);

      // CMD0: accepted, never answered
      ev = '{EV_VALID, 6'd0, 32'd0};
      ev_q[0].push_back(ev);
      send(0, mk_frame(1'b1, 6'd0, 32'd0, 7'h4A, 1'b1));
      repeat (100) @(negedge sd_clk);

      // CMD8 with R1 response after NCR=2
      bus_a.card_status = 32'h0000_0900;
      ev = '{EV_VALID, 6'd8, 32'h0000_01AA};
      ev_q[0].push_back(ev);
      rs = '{mk_resp(6'd8, 32'h0000_0900), 48, 2};
      rs_q[0].push_back(rs);
      send(0, mk_frame(1'b1, 6'd8, 32'h0000_01AA, 7'h43, 1'b1));
      repeat (70) @(negedge sd_clk);

      // CMD8 with CRC LSB flipped: crc_error, previous index/arg held
      ev = '{EV_CRC, 6'd8, 32'h0000_01AA};
      ev_q[0].push_back(ev);
      send(0, mk_frame(1'b1, 6'd8, 32'h0000_01AA, 7'h42, 1'b1));
      repeat (60) @(negedge sd_clk);

      // CMD17 with correct CRC for tx=1, sent with tx=0: frame_error wins
      crc17 = crc7_model({2'b01, 6'd17, 32'h0000_0200});
      ev = '{EV_FRAME, 6'd8, 32'h0000_01AA};
      ev_q[0].push_back(ev);
      send(0, mk_frame(1'b0, 6'd17, 32'h0000_0200, crc17, 1'b1));
      repeat (60) @(negedge sd_clk);

      // CMD8, then reset while response bit 20 would be driven
      bus_a.card_status = 32'hA5A5_0F0F;
      ev = '{EV_VALID, 6'd8, 32'h0000_01AA};
      ev_q[0].push_back(ev);
      rs = '{mk_resp(6'd8, 32'hA5A5_0F0F), 20, 2};
      rs_q[0].push_back(rs);
      send(0, mk_frame(1'b1, 6'd8, 32'h0000_01AA, 7'h43, 1'b1));
      e = cyc;
      wait_until(e + 22);
      rst_L = 1'b0;
      @(negedge sd_clk);
      chk("midresp_rst_oe",    48'(bus_a.cmd_to_host_oe), 48'd0);
      chk("midresp_rst_line",  48'(bus_a.cmd_to_host), 48'd1);
      chk("midresp_rst_index", 48'(bus_a.cmd_index), 48'd0);
      rst_L = 1'b1;
      repeat (3) @(negedge sd_clk);

      // normal CMD8 after reset
      bus_a.card_status = 32'h0000_0120;
      ev = '{EV_VALID, 6'd8, 32'h0000_01AA};
      ev_q[0].push_back(ev);
      rs = '{mk_resp(6'd8, 32'h0000_0120), 48, 2};
      rs_q[0].push_back(rs);
      send(0, mk_frame(1'b1, 6'd8, 32'h0000_01AA, 7'h43, 1'b1));
      repeat (70) @(negedge sd_clk);

      // NCR=64: two CMD8 back-to-back, host toggles the line during the gap
      bus_b.card_status = 32'h0000_0900;
      ev = '{EV_VALID, 6'd8, 32'h0000_01AA};
      ev_q[1].push_back(ev);
      rs = '{mk_resp(6'd8, 32'h0000_0900), 48, 64};
      rs_q[1].push_back(rs);
      send(1, mk_frame(1'b1, 6'd8, 32'h0000_01AA, 7'h43, 1'b1));
      e = cyc;
      for (int k = 0; k < 64; k++) begin
         drive(1, (k % 2) != 0);
         @(negedge sd_clk);
      end
      drive(1, 1'b1);
      bus_b.card_status = 32'h0000_0B00;
      ev_q[1].push_back(ev);
      rs = '{mk_resp(6'd8, 32'h0000_0B00), 48, 64};
      rs_q[1].push_back(rs);
      // first IDLE edge after the response is e+114
      wait_until(e + 113);
      send(1, mk_frame(1'b1, 6'd8, 32'h0000_01AA, 7'h43, 1'b1));
      repeat (130) @(negedge sd_clk);

      chk("pending_events_a", 48'(ev_q[0].size()), 48'd0);
      chk("pending_resps_a",  48'(rs_q[0].size()), 48'd0);
      chk("pending_events_b", 48'(ev_q[1].size()), 48'd0);
      chk("pending_resps_b",  48'(rs_q[1].size()), 48'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
